axi_wr_responder: RTL and testbench

- Slave/responder end of the scope's simplified AXI write-master port (waddr/wdata/wsel/wvalid/wlen/wfixed out, wrdy/werr in).
- Accepts write beats with programmable back-pressure and stores them in an internal word RAM.
- Checks burst protocol and address window, and exposes a one-cycle-latency read-back port plus statistics.
- Used as the memory model behind scope channels A/B in simulation and as a BRAM sink in small-footprint builds.

---
 rtl/axi_wr_responder_pkg.sv | 20 ++
 rtl/axi_wr_responder_if.sv | 28 ++
 rtl/axi_wr_responder_ram.sv | 49 ++++
 rtl/axi_wr_responder.sv | 184 ++++++++++++++++++
 tb/tb_axi_wr_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_responder_pkg.sv
// Shared types and helpers for the AXI write responder.
package axi_wr_responder_pkg;

  typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

  localparam int unsigned DW_DEF  = 64;
  localparam int unsigned AW_DEF  = 32;
  localparam int unsigned MSZ_DEF = 10;

  // log2 of bytes per word at the default data width
  localparam int unsigned BYTE_SHIFT = $clog2(DW_DEF / 8);

  // True when addr lies inside [base, base + size)
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/axi_wr_responder_if.sv
// Simplified AXI write beat channel between a scope write master and its responder.
interface axi_wr_responder_if
  import axi_wr_responder_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) ();

  logic [AW-1:0]   waddr_i;
  logic [DW-1:0]   wdata_i;
  logic [DW/8-1:0] wsel_i;
  logic            wvalid_i;
  logic [3:0]      wlen_i;
  logic            wfixed_i;
  logic            wrdy_o;
  logic            werr_o;

  modport master (
    output waddr_i, wdata_i, wsel_i, wvalid_i, wlen_i, wfixed_i,
    input  wrdy_o, werr_o
  );

  modport slave (
    input  waddr_i, wdata_i, wsel_i, wvalid_i, wlen_i, wfixed_i,
    output wrdy_o, werr_o
  );

endinterface

// File: rtl/axi_wr_responder_ram.sv
// Byte-enabled single-port-write RAM with a registered, read-first read port.
module axi_wr_responder_ram
  import axi_wr_responder_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned MSZ = MSZ_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [MSZ-1:0]  waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wsel_i,
  input  logic            rd_en_i,
  input  logic [MSZ-1:0]  rd_addr_i,
  output logic [DW-1:0]   rd_data_o,
  output logic            rd_vld_o
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0] r_mem [2**MSZ];
  logic [DW-1:0] r_rd_data;
  logic          r_rd_vld;

  // Byte-lane writes; no reset so the array maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wsel_i[b]) r_mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Registered read; sees the pre-write contents on a same-word collision
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= rd_en_i;
      if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;
  assign rd_vld_o  = r_rd_vld;

endmodule

// File: rtl/axi_wr_responder.sv
// Write responder: accepts burst beats with back-pressure, checks them and stores them in RAM.
module axi_wr_responder
  import axi_wr_responder_pkg::*;
#(
  parameter int unsigned   DW   = DW_DEF,
  parameter int unsigned   AW   = AW_DEF,
  parameter int unsigned   MSZ  = MSZ_DEF,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  axi_wr_responder_if.slave        wr,
  input  logic [3:0]               stall_i,
  input  logic                     clr_i,
  input  logic                     rd_en_i,
  input  logic [MSZ-1:0]           rd_addr_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_vld_o,
  output logic [31:0]              beat_cnt_o,
  output logic [15:0]              burst_cnt_o,
  output logic                     err_o
);

  localparam int unsigned NB        = DW / 8;
  localparam int unsigned WSH       = (DW == DW_DEF) ? BYTE_SHIFT : $clog2(DW / 8);
  localparam logic [63:0] WIN_BYTES = 64'(1) << (MSZ + WSH);

  state_t        r_state, w_state_n, r_pend, w_pend_n, w_after;
  logic [AW-1:0] r_base, w_base_n;
  logic [3:0]    r_len, w_len_n;
  logic          r_fixed, w_fixed_n;
  logic [3:0]    r_idx, w_idx_n;
  logic [3:0]    r_stall, w_stall_n;
  logic          r_live;

  logic [31:0]   r_beat_cnt;
  logic [15:0]   r_burst_cnt;
  logic          r_err;
  logic          r_werr;

  logic          w_rdy, w_acc, w_last, w_ok, w_mis, w_we;
  logic [3:0]    w_idx_cur, w_len_cur;
  logic [AW-1:0] w_exp_addr;
  logic [MSZ-1:0] w_word;

  // FSM state register; r_live holds wrdy low until the first edge after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_pend  <= IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_idx   <= '0;
      r_stall <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_base  <= w_base_n;
      r_len   <= w_len_n;
      r_fixed <= w_fixed_n;
      r_idx   <= w_idx_n;
      r_stall <= w_stall_n;
      r_live  <= 1'b1;
    end
  end

  // Next-state: burst tracking and stall insertion after every accepted beat
  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_base_n  = r_base;
    w_len_n   = r_len;
    w_fixed_n = r_fixed;
    w_idx_n   = r_idx;
    w_stall_n = r_stall;
    w_after   = IDLE;
    if (clr_i) begin
      w_state_n = IDLE;
      w_pend_n  = IDLE;
      w_idx_n   = '0;
      w_stall_n = '0;
    end else begin
      unique case (r_state)
        IDLE, BURST: begin
          if (w_acc) begin
            if (r_state == IDLE) begin
              w_base_n  = wr.waddr_i;
              w_len_n   = wr.wlen_i;
              w_fixed_n = wr.wfixed_i;
            end
            if (w_last) begin
              w_after = IDLE;
              w_idx_n = '0;
            end else begin
              w_after = BURST;
              w_idx_n = w_idx_cur + 4'd1;
            end
            if (stall_i != 4'd0) begin
              w_state_n = STALL;
              w_pend_n  = w_after;
              w_stall_n = stall_i;
            end else begin
              w_state_n = w_after;
            end
          end
        end
        STALL: begin
          if (r_stall <= 4'd1) begin
            w_state_n = r_pend;
            w_stall_n = '0;
          end else begin
            w_stall_n = r_stall - 4'd1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // Outputs and beat decode: handshake, expected address, window/alignment check
  always_comb begin
    w_rdy      = r_live & ~clr_i & (r_state != STALL);
    w_acc      = wr.wvalid_i & w_rdy;
    w_idx_cur  = (r_state == BURST) ? r_idx : 4'd0;
    w_len_cur  = (r_state == BURST) ? r_len : wr.wlen_i;
    w_last     = (w_idx_cur == w_len_cur);
    if (r_state == BURST) begin
      w_exp_addr = r_fixed ? r_base : r_base + (AW'(r_idx) << WSH);
    end else begin
      w_exp_addr = wr.waddr_i;
    end
    // A mismatching beat is still written at the expected address
    w_mis  = w_acc & (r_state == BURST) & (wr.waddr_i != w_exp_addr);
    w_ok   = in_window(64'(w_exp_addr), 64'(BASE), WIN_BYTES) &&
             ((w_exp_addr & AW'(NB - 1)) == '0);
    w_we   = w_acc & w_ok;
    w_word = MSZ'((w_exp_addr - BASE) >> WSH);
  end

  // Statistics, sticky protocol error and the rejected-beat pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_err       <= 1'b0;
      r_werr      <= 1'b0;
    end else if (clr_i) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_err       <= 1'b0;
      r_werr      <= 1'b0;
    end else begin
      r_werr <= w_acc & ~w_ok;
      if (w_we)           r_beat_cnt  <= r_beat_cnt + 32'd1;
      if (w_acc & w_last) r_burst_cnt <= r_burst_cnt + 16'd1;
      if (w_mis)          r_err       <= 1'b1;
    end
  end

  axi_wr_responder_ram #(
    .DW  (DW),
    .MSZ (MSZ)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (w_we),
    .waddr_i   (w_word),
    .wdata_i   (wr.wdata_i),
    .wsel_i    (wr.wsel_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_vld_o  (rd_vld_o)
  );

  assign wr.wrdy_o   = w_rdy;
  assign wr.werr_o   = r_werr;
  assign beat_cnt_o  = r_beat_cnt;
  assign burst_cnt_o = r_burst_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Bench for axi_wr_responder: beat-level memory/counter model plus directed literal checks.
module tb_axi_wr_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  stall = 4'd0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic [31:0] beat_cnt;
  logic [15:0] burst_cnt;
  logic        err;

  axi_wr_responder_if wr_if ();

  axi_wr_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr          (wr_if),
    .stall_i     (stall),
    .clr_i       (clr),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_vld_o    (rd_vld),
    .beat_cnt_o  (beat_cnt),
    .burst_cnt_o (burst_cnt),
    .err_o       (err)
  );

  initial forever #5 clk = ~clk;

  // Model state: memory image and what each output must show
  logic [63:0] mem_m [1024];
  logic [63:0] bdata [16];
  logic [31:0] m_beat = '0;
  logic [15:0] m_burst = '0;
  logic        m_err = 1'b0, m_werr = 1'b0, m_rdv = 1'b0, m_live = 1'b0;
  logic [63:0] m_rdd = '0;
  int          m_stall_left = 0;
  int          cyc = 0, acc_cyc = 0, first_cyc = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One-cycle model pulses expire at each edge; a fresh event re-sets them after it
  initial forever begin
    @(posedge clk);
    cyc++;
    m_werr = 1'b0;
    m_rdv  = 1'b0;
    if (!rst) m_live = 1'b1;
  end

  // Compare every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    chk("wrdy", 64'(wr_if.wrdy_o), 64'(m_live && !clr && m_stall_left == 0));
    chk("werr", 64'(wr_if.werr_o), 64'(m_werr));
    chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
    chk("burst_cnt", 64'(burst_cnt), 64'(m_burst));
    chk("err", 64'(err), 64'(m_err));
    chk("rd_vld", 64'(rd_vld), 64'(m_rdv));
    chk("rd_data", rd_data, m_rdd);
    if (m_stall_left > 0) m_stall_left--;
  end

  // Offer one beat at drv (model target e), wait for acceptance, then update the model
  task automatic beat(input logic [31:0] drv, input logic [31:0] e, input logic [63:0] d,
                      input logic [7:0] s, input logic [3:0] l, input logic f,
                      input logic [3:0] st, input logic last);
    int w;
    int unsigned wi;
    w = 0;
    wr_if.waddr_i  = drv;
    wr_if.wdata_i  = d;
    wr_if.wsel_i   = s;
    wr_if.wlen_i   = l;
    wr_if.wfixed_i = f;
    wr_if.wvalid_i = 1'b1;
    stall = st;
    @(negedge clk);
    while (!wr_if.wrdy_o && w < 40) begin
      w++;
      @(negedge clk);
    end
    if (!wr_if.wrdy_o) begin
      chk("beat_accept_timeout", 64'd0, 64'd1);
      wr_if.wvalid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    wr_if.wvalid_i = 1'b0;
    acc_cyc = cyc;
    if (e < 32'h2000 && e[2:0] == 3'b000) begin
      wi = e >> 3;
      for (int b = 0; b < 8; b++) if (s[b]) mem_m[wi][b*8 +: 8] = d[b*8 +: 8];
      m_beat++;
    end else begin
      m_werr = 1'b1;
    end
    if (drv != e) m_err = 1'b1;
    m_stall_left = st;
    if (last) m_burst++;
  endtask

  // Send nb beats of a burst from bdata[]; beat index bad is driven at bad_a instead
  task automatic burst(input logic [31:0] a, input logic [3:0] l, input logic f,
                       input logic [3:0] st, input int nb, input int bad,
                       input logic [31:0] bad_a, input logic [7:0] s);
    logic [31:0] e;
    for (int i = 0; i < nb; i++) begin
      e = f ? a : a + 32'(i) * 32'd8;
      beat((i == bad) ? bad_a : e, e, bdata[i], s, l, f, st, i == int'(l));
      if (i == 0) first_cyc = acc_cyc;
    end
  endtask

  task automatic rd(input int idx);
    logic [63:0] e;
    e = mem_m[idx];
    rd_en = 1'b1;
    rd_addr = 10'(idx);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    m_rdv = 1'b1;
    m_rdd = e;
  endtask

  task automatic rdchk(input string nm, input int idx, input logic [63:0] lit);
    rd(idx);
    chk(nm, rd_data, lit);
    chk({nm, "_vld"}, 64'(rd_vld), 64'd1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_beat = '0;
    m_burst = '0;
    m_err = 1'b0;
    m_stall_left = 0;
  endtask

  task automatic model_reset();
    m_beat = '0;
    m_burst = '0;
    m_err = 1'b0;
    m_werr = 1'b0;
    m_rdv = 1'b0;
    m_rdd = '0;
    m_live = 1'b0;
    m_stall_left = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_if.waddr_i = '0; wr_if.wdata_i = '0; wr_if.wsel_i = '0;
    wr_if.wvalid_i = 1'b0; wr_if.wlen_i = '0; wr_if.wfixed_i = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrdy", 64'(wr_if.wrdy_o), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("wrdy_after_rst", 64'(wr_if.wrdy_o), 64'd1);

    // Incrementing 4-beat burst, no stall
    bdata[0] = 64'hA0A0_0000_0000_0000; bdata[1] = 64'hA1A1_0000_0000_0001;
    bdata[2] = 64'hA2A2_0000_0000_0002; bdata[3] = 64'hA3A3_0000_0000_0003;
    burst(32'h100, 4'd3, 1'b0, 4'd0, 4, -1, 32'h0, 8'hFF);
    chk("t1_beat_cnt", 64'(beat_cnt), 64'd4);
    chk("t1_burst_cnt", 64'(burst_cnt), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_span", 64'(acc_cyc - first_cyc), 64'd3);
    rdchk("t1_ram32", 32, 64'hA0A0_0000_0000_0000);
    rdchk("t1_ram35", 35, 64'hA3A3_0000_0000_0003);

    // Same burst with two stall cycles after each beat
    do_clr();
    bdata[0] = 64'hC0; bdata[1] = 64'hC1; bdata[2] = 64'hC2; bdata[3] = 64'hC3;
    burst(32'h100, 4'd3, 1'b0, 4'd2, 4, -1, 32'h0, 8'hFF);
    chk("t2_span", 64'(acc_cyc - first_cyc), 64'd9);
    chk("t2_beat_cnt", 64'(beat_cnt), 64'd4);
    chk("t2_burst_cnt", 64'(burst_cnt), 64'd1);
    rdchk("t2_ram33", 33, 64'hC1);

    // Fixed-address burst
    do_clr();
    bdata[0] = 64'd1; bdata[1] = 64'd2; bdata[2] = 64'd3;
    burst(32'h40, 4'd2, 1'b1, 4'd0, 3, -1, 32'h0, 8'hFF);
    chk("t3_beat_cnt", 64'(beat_cnt), 64'd3);
    chk("t3_err", 64'(err), 64'd0);
    rdchk("t3_ram8", 8, 64'd3);

    // Out-of-window and misaligned single beats
    do_clr();
    bdata[0] = 64'h5A5A_5A5A_0000_0001;
    burst(32'h0, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
    bdata[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    burst(32'h2000, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
    chk("t4_werr_pulse", 64'(wr_if.werr_o), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_werr_drop", 64'(wr_if.werr_o), 64'd0);
    burst(32'h104, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
    chk("t4_werr_misalign", 64'(wr_if.werr_o), 64'd1);
    chk("t4_beat_cnt", 64'(beat_cnt), 64'd1);
    chk("t4_burst_cnt", 64'(burst_cnt), 64'd3);
    rdchk("t4_ram0", 0, 64'h5A5A_5A5A_0000_0001);

    // Address mismatch on beat 2
    do_clr();
    bdata[0] = 64'hB0; bdata[1] = 64'hB1; bdata[2] = 64'hB2; bdata[3] = 64'hB3;
    burst(32'h200, 4'd3, 1'b0, 4'd0, 4, 2, 32'h300, 8'hFF);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_burst_cnt", 64'(burst_cnt), 64'd1);
    rdchk("t5_ram66", 66, 64'hB2);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_err_sticky", 64'(err), 64'd1);
    do_clr();
    chk("t5_err_clr", 64'(err), 64'd0);

    // Byte enables, read-back and read-first collision
    bdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    burst(32'h80, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
    bdata[0] = 64'h1111_1111_2222_2222;
    burst(32'h80, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'h0F);
    rdchk("t6_wsel", 16, 64'hFFFF_FFFF_2222_2222);
    bdata[0] = 64'h3333_3333_3333_3333;
    fork
      burst(32'h80, 4'd0, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
      rd(16);
    join
    chk("t6_read_first", rd_data, 64'hFFFF_FFFF_2222_2222);
    rdchk("t6_after_write", 16, 64'h3333_3333_3333_3333);

    // Reset after the first beat of a 4-beat burst
    bdata[0] = 64'hE0; bdata[1] = 64'hE1;
    burst(32'h300, 4'd3, 1'b0, 4'd0, 1, -1, 32'h0, 8'hFF);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t7_wrdy", 64'(wr_if.wrdy_o), 64'd0);
    chk("t7_werr", 64'(wr_if.werr_o), 64'd0);
    chk("t7_rd_vld", 64'(rd_vld), 64'd0);
    chk("t7_rd_data", rd_data, 64'd0);
    chk("t7_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("t7_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("t7_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    burst(32'h400, 4'd1, 1'b0, 4'd0, 2, -1, 32'h0, 8'hFF);
    chk("t7_new_beat_cnt", 64'(beat_cnt), 64'd2);
    chk("t7_new_burst_cnt", 64'(burst_cnt), 64'd1);
    rdchk("t7_ram129", 129, 64'hE1);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
